// File: rtl/proc_context_pkg.sv
// Shared core definitions: context FSM encodings and default PC / time-slice widths.
// Also used by the control unit and the PC register.
package proc_context_pkg;

  localparam int PC_W_DEF = 10;
  localparam int QW_DEF   = 16;

  typedef enum logic [1:0] {
    OS_RUN     = 2'b00,
    SWITCH_IN  = 2'b01,
    PROC_RUN   = 2'b10,
    SWITCH_OUT = 2'b11
  } ctx_state_e;

  function automatic logic in_switch(input ctx_state_e s);
    return (s == SWITCH_IN) || (s == SWITCH_OUT);
  endfunction

endpackage

// File: rtl/proc_context.sv
// Process context manager: switches the PC between the OS and one user process,
// preempting the process when its time slice (counted in non-halted cycles) runs out.
module proc_context
  import proc_context_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int QW   = QW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Halt,
  input  logic            exec_process,
  input  logic            select_proc_reg_write,
  input  logic            select_proc_reg_read,
  input  logic            change_pc,
  input  logic            end_proc,
  input  logic [PC_W-1:0] next_pc,
  input  logic [PC_W-1:0] target_pc,
  input  logic [QW-1:0]   quantum,
  output logic            curr_exec_process,
  output logic            curr_select_proc_reg_write,
  output logic            curr_select_proc_reg_read,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_load_value,
  output logic [PC_W-1:0] proc_saved_pc,
  output logic            preempted,
  output logic [1:0]      ctx_state
);

  ctx_state_e      state, state_nxt;
  logic [PC_W-1:0] os_ret;
  logic [QW-1:0]   counter;
  logic            do_start, do_end, expire;

  assign do_start = (state == OS_RUN) && change_pc;
  assign do_end   = (state == PROC_RUN) && end_proc;
  // end_proc wins over a coincident expiry, so expiry requires end_proc low
  assign expire   = (state == PROC_RUN) && (quantum != '0) && (counter == QW'(1))
                    && !Halt && !end_proc;

  always_ff @(posedge clk) begin
    if (rst) state <= OS_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OS_RUN:     if (do_start) state_nxt = SWITCH_IN;
      SWITCH_IN:  state_nxt = PROC_RUN;
      PROC_RUN:   if (do_end || expire) state_nxt = SWITCH_OUT;
      SWITCH_OUT: state_nxt = OS_RUN;
      default:    state_nxt = OS_RUN;
    endcase
  end

  always_comb begin
    pc_load = in_switch(state);
  end

  assign ctx_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      curr_exec_process          <= 1'b0;
      curr_select_proc_reg_write <= 1'b0;
      curr_select_proc_reg_read  <= 1'b0;
    end else if (expire) begin
      curr_exec_process          <= 1'b0;
      curr_select_proc_reg_write <= 1'b0;
      curr_select_proc_reg_read  <= 1'b0;
    end else if (!in_switch(state)) begin
      curr_exec_process          <= exec_process;
      curr_select_proc_reg_write <= select_proc_reg_write;
      curr_select_proc_reg_read  <= select_proc_reg_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      os_ret        <= '0;
      pc_load_value <= '0;
      proc_saved_pc <= '0;
      preempted     <= 1'b0;
      counter       <= '0;
    end else if (do_start) begin
      os_ret        <= next_pc;
      pc_load_value <= target_pc;
      counter       <= quantum;
      preempted     <= 1'b0;
    end else if (do_end) begin
      pc_load_value <= os_ret;
      preempted     <= 1'b0;
    end else if (expire) begin
      proc_saved_pc <= next_pc;
      pc_load_value <= os_ret;
      preempted     <= 1'b1;
    end else if ((state == PROC_RUN) && !Halt && (quantum != '0) && (counter > QW'(1))) begin
      counter <= counter - QW'(1);
    end
  end

endmodule
